// File: rtl/bram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// bram_fifo_pkg : shared constants and helpers for bram_stream_fifo | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bram_fifo_pkg;

  localparam int SKID_DEPTH = 2;

  // Level needs AW+2 bits: RAM holds up to DEPTH words plus SKID_DEPTH outside it
  localparam int LEVEL_XBITS = 2;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2 : two-entry register FIFO used as the output stage | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module skid_buf2
  import bram_fifo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  assign head_data = ent0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            ent0 <= push_data;
          end else if (count == 2'd1) begin
            ent1 <= push_data;
          end
          if (count < 2'(SKID_DEPTH)) begin
            count <= count + 2'd1;
          end
        end
        2'b01: begin
          ent0 <= ent1;
          if (count != 2'd0) begin
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous capture and pop: the new word lands behind whatever remains
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_data;
          end else begin
            ent0 <= push_data;
            if (count == 2'd0) begin
              count <= 2'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_stream_fifo.sv
// ---------------------------------------------------------------------------
// bram_stream_fifo : valid/ready stream FIFO on an external dual-port RAM | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bram_stream_fifo
  import bram_fifo_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [AW+LEVEL_XBITS-1:0] level,
  output logic                     ram_write_en_a,
  output logic [AW-1:0]            ram_addr_a,
  output logic [WIDTH-1:0]         ram_data_in_a,
  output logic                     ram_read_en_b,
  output logic [AW-1:0]            ram_addr_b,
  input  logic [WIDTH-1:0]         ram_data_out_b
);

  localparam int LW = AW + LEVEL_XBITS;
  typedef logic [LW-1:0] level_t;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   ram_cnt;
  logic [AW:0]   ram_cnt_nx;
  logic          rd_inflight;
  logic          active;
  logic [1:0]    skid_cnt;
  logic [1:0]    skid_cnt_nx;
  logic [2:0]    skid_occ;
  logic          push;
  logic          pop_ram;
  logic          pop_skid;
  logic          cap_skid;

  // active keeps s_ready (and so writes) low while rst is asserted
  assign s_ready  = active & ~clear & (ram_cnt != (AW+1)'(DEPTH));
  assign push     = s_valid & s_ready;
  assign m_valid  = (skid_cnt != 2'd0);
  assign pop_skid = m_valid & m_ready & ~clear;
  assign cap_skid = rd_inflight & ~clear;

  // Reads are only issued when the skid stage is guaranteed a free slot on return
  assign skid_occ = {1'b0, skid_cnt} + {2'b00, rd_inflight};
  assign pop_ram  = ~clear & (ram_cnt != '0) & (skid_occ < (3'd2 + {2'b00, pop_skid}));

  assign ram_write_en_a = push;
  assign ram_addr_a     = wr_ptr;
  assign ram_data_in_a  = s_data;
  assign ram_read_en_b  = pop_ram;
  assign ram_addr_b     = rd_ptr;

  always_comb begin
    ram_cnt_nx  = ram_cnt;
    skid_cnt_nx = skid_cnt;
    if (clear) begin
      ram_cnt_nx  = '0;
      skid_cnt_nx = '0;
    end else begin
      ram_cnt_nx  = ram_cnt + (AW+1)'(push) - (AW+1)'(pop_ram);
      skid_cnt_nx = skid_cnt + 2'(cap_skid) - 2'(pop_skid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      active      <= 1'b0;
      level       <= '0;
    end else begin
      active      <= 1'b1;
      ram_cnt     <= ram_cnt_nx;
      rd_inflight <= pop_ram;
      level       <= level_t'(ram_cnt_nx) + level_t'(pop_ram) + level_t'(skid_cnt_nx);
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= AW'(ptr_inc(32'(wr_ptr), DEPTH));
        end
        if (pop_ram) begin
          rd_ptr <= AW'(ptr_inc(32'(rd_ptr), DEPTH));
        end
      end
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (cap_skid),
    .push_data (ram_data_out_b),
    .pop       (pop_skid),
    .head_data (m_data),
    .count     (skid_cnt)
  );

  always @(posedge clk) begin
    if (!rst) begin
      assert (ram_cnt <= (AW+1)'(DEPTH));
      assert (skid_cnt <= 2'(SKID_DEPTH));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_fifo : directed self-checking bench with a behavioural RAM | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bram_stream_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [WIDTH-1:0] s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic [AW+1:0]    level;
  logic             ram_write_en_a;
  logic [AW-1:0]    ram_addr_a;
  logic [WIDTH-1:0] ram_data_in_a;
  logic             ram_read_en_b;
  logic [AW-1:0]    ram_addr_b;
  logic [WIDTH-1:0] ram_data_out_b = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_acc    = 0;

  always #5 clk = ~clk;

  bram_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .level          (level),
    .ram_write_en_a (ram_write_en_a),
    .ram_addr_a     (ram_addr_a),
    .ram_data_in_a  (ram_data_in_a),
    .ram_read_en_b  (ram_read_en_b),
    .ram_addr_b     (ram_addr_b),
    .ram_data_out_b (ram_data_out_b)
  );

  // Dual-port RAM with registered read
  always @(posedge clk) begin
    if (ram_write_en_a) mem[ram_addr_a] <= ram_data_in_a;
    if (ram_read_en_b) ram_data_out_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One clock: record handshakes seen just before the edge, check outputs in order
  task automatic tick();
    #1;
    if (m_valid && m_ready) begin
      n_out++;
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("out_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
    if (s_valid && s_ready) begin
      exp_q.push_back(s_data);
      n_acc++;
    end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_we", 32'(ram_write_en_a), 32'd0);
    chk("rst_re", 32'(ram_read_en_b), 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Single word: 3-cycle latency, level returns to 0
    s_valid = 1'b1; s_data = 16'hABCD; m_ready = 1'b1;
    #1;
    chk("sw_we", 32'(ram_write_en_a), 32'd1);
    chk("sw_addr_a", 32'(ram_addr_a), 32'd0);
    chk("sw_din", 32'(ram_data_in_a), 32'hABCD);
    cyc();
    s_valid = 1'b0;
    #1;
    chk("sw_re", 32'(ram_read_en_b), 32'd1);
    chk("sw_addr_b", 32'(ram_addr_b), 32'd0);
    chk("sw_mv_t0", 32'(m_valid), 32'd0);
    chk("sw_level_t0", 32'(level), 32'd1);
    cyc();
    chk("sw_mv_t1", 32'(m_valid), 32'd0);
    chk("sw_level_t1", 32'(level), 32'd1);
    cyc();
    chk("sw_mv_t2", 32'(m_valid), 32'd1);
    chk("sw_data", 32'(m_data), 32'hABCD);
    cyc();
    chk("sw_mv_t3", 32'(m_valid), 32'd0);
    chk("sw_level_t3", 32'(level), 32'd0);

    // Streaming: 256 words, one per clock, last one out on tick 259
    n_acc = 0; n_out = 0; m_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      tick();
    end
    s_valid = 1'b0;
    repeat (3) tick();
    chk("st_accepted", 32'(n_acc), 32'd256);
    chk("st_out_count", 32'(n_out), 32'd256);
    chk("st_level", 32'(level), 32'd0);
    chk("st_m_valid", 32'(m_valid), 32'd0);

    // Backpressure: 18 words fit (16 RAM + 2 skid)
    n_acc = 0; n_out = 0; m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1; s_data = 16'h0100 + 16'(n_acc);
      tick();
    end
    chk("bp_accepted", 32'(n_acc), 32'd18);
    chk("bp_s_ready", 32'(s_ready), 32'd0);
    chk("bp_level", 32'(level), 32'd18);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_head", 32'(m_data), 32'h0100);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_out_count", 32'(n_out), 32'd18);
    chk("bp_level_end", 32'(level), 32'd0);

    // Wrap-around: 48 words with random consumer stalls
    n_acc = 0; n_out = 0;
    for (int c = 0; c < 600 && n_out < 48; c++) begin
      s_valid = (n_acc < 48); s_data = 16'h0800 + 16'(n_acc);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("wr_accepted", 32'(n_acc), 32'd48);
    chk("wr_out_count", 32'(n_out), 32'd48);
    // 1 + 256 + 18 + 48 = 323 words so far; 323 mod 16 = 3
    chk("wr_addr_a", 32'(ram_addr_a), 32'd3);
    chk("wr_addr_b", 32'(ram_addr_b), 32'd3);
    chk("wr_level", 32'(level), 32'd0);

    // Clear with a read in flight
    n_acc = 0; n_out = 0;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1; s_data = 16'h0200 + 16'(n_acc);
      tick();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    #1;
    chk("cl_read_issue", 32'(ram_read_en_b), 32'd1);
    tick();
    chk("cl_level_pre", 32'(level), 32'd9);
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'hDEAD; clear = 1'b1;
    #1;
    chk("cl_we_supp", 32'(ram_write_en_a), 32'd0);
    chk("cl_re_supp", 32'(ram_read_en_b), 32'd0);
    cyc();
    clear = 1'b0; s_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("cl_m_valid", 32'(m_valid), 32'd0);
    chk("cl_level", 32'(level), 32'd0);
    n_out = 0;
    s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    #1;
    chk("cl_addr_a", 32'(ram_addr_a), 32'd0);
    tick();
    s_valid = 1'b0;
    repeat (6) tick();
    chk("cl_out_count", 32'(n_out), 32'd1);
    chk("cl_level_end", 32'(level), 32'd0);

    // Asynchronous reset between edges with 5 words held
    n_acc = 0; m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'b1; s_data = 16'h0300 + 16'(n_acc);
      tick();
    end
    s_valid = 1'b0;
    repeat (2) tick();
    chk("ar_level_pre", 32'(level), 32'd5);
    s_valid = 1'b1; s_data = 16'h0999; m_ready = 1'b1;
    #2;
    chk("ar_we_pre", 32'(ram_write_en_a), 32'd1);
    chk("ar_re_pre", 32'(ram_read_en_b), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_m_valid", 32'(m_valid), 32'd0);
    chk("ar_we", 32'(ram_write_en_a), 32'd0);
    chk("ar_re", 32'(ram_read_en_b), 32'd0);
    chk("ar_level", 32'(level), 32'd0);
    s_valid = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
    n_out = 0;
    s_valid = 1'b1; s_data = 16'h4321; m_ready = 1'b1;
    #1;
    chk("ar_addr_a", 32'(ram_addr_a), 32'd0);
    tick();
    s_valid = 1'b0;
    #1;
    chk("ar_addr_b", 32'(ram_addr_b), 32'd0);
    repeat (5) tick();
    chk("ar_out_count", 32'(n_out), 32'd1);
    chk("ar_level_end", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
